// File: rtl/uart_rx_framed_if.sv
// uart_rx_framed_if -- receive-side handshake bundle for uart_rx_framed.
//   po_data    : received word, LSB = first data bit on the line
//   po_valid   : po_data and the error flags hold an unconsumed frame
//   po_ready   : consumer accept; a transfer happens on po_valid && po_ready
//   frame_err  : stop bit sampled 0 (valid while po_valid)
//   parity_err : parity mismatch (valid while po_valid)
//   overrun    : 1-cycle pulse when an unconsumed frame is overwritten
// master = receiver (drives the frame), slave = consumer (drives po_ready).
interface uart_rx_framed_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] po_data;
   logic                 po_valid;
   logic                 po_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output po_data, po_valid, frame_err, parity_err, overrun,
      input  po_ready
   );

   modport slave (
      input  po_data, po_valid, frame_err, parity_err, overrun,
      output po_ready
   );
endinterface

// File: rtl/uart_rx_framed.sv
// uart_rx_framed -- UART receiver with 2-of-3 majority bit decisions, optional
// parity check and a one-deep holding register with valid/ready handoff.
// Ports:
//   clk      : system clock, rising edge
//   rstn     : asynchronous active-low reset
//   rs232_rx : asynchronous serial line, idle high
//   m        : uart_rx_framed_if.master (po_data/po_valid/po_ready/
//              frame_err/parity_err/overrun)
// Build option: define UART_RX_PARITY_EN to build the PAR state and parity
// checker (active for PARITY 1 = odd, 2 = even). Without it the frame is
// start + DATA_BITS + stop and parity_err stays 0.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronised line
// START | verifying the start bit, glitches return to IDLE
// DATA  | shifting in DATA_BITS data bits, LSB first
// PAR   | checking the parity bit (parity build only)
// STOP  | sampling the stop bit, loading the holding register
module uart_rx_framed #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int UART_BPS  = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             rs232_rx,
   uart_rx_framed_if.master m
);
   localparam int BAUD_MAX = CLK_FREQ / UART_BPS;
   localparam int CW       = $clog2(BAUD_MAX);
   localparam int H        = BAUD_MAX / 2;

   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_MAX - 1);
   localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
   localparam logic [CW-1:0] CNT_H    = CW'(H);
   localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
   localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_ACT = (PARITY == 1) || (PARITY == 2);
`else
   // no parity hardware in this build, whatever PARITY says
   localparam bit PAR_ACT = 1'b0 && (PARITY != 0);
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PAR,
`endif
      STOP
   } state_t;

   state_t               state;
   logic                 rx_s1, rx_s2, rx_d;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_cnt;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;

   logic at_dec, at_end, maj;
   assign at_dec = (cnt == CNT_DEC);
   assign at_end = (cnt == CNT_LAST);
   // third vote is the live synchronised line at the decision count
   assign maj    = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);

`ifdef UART_RX_PARITY_EN
   logic par_exp;
   assign par_exp = (PARITY == 1) ? ~^shreg : ^shreg;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_d         <= 1'b1;
         state        <= IDLE;
         cnt          <= '0;
         bit_cnt      <= '0;
         samp         <= '0;
         shreg        <= '0;
         par_bad      <= 1'b0;
         m.po_data    <= '0;
         m.po_valid   <= 1'b0;
         m.frame_err  <= 1'b0;
         m.parity_err <= 1'b0;
         m.overrun    <= 1'b0;
      end else begin
         rx_s1     <= rs232_rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         m.overrun <= 1'b0;

         // a load in STOP below overrides this release
         if (m.po_valid && m.po_ready)
            m.po_valid <= 1'b0;

         if (state != IDLE) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
            if (cnt == CNT_HM1) samp[0] <= rx_s2;
            if (cnt == CNT_H)   samp[1] <= rx_s2;
         end

         case (state)
            IDLE: begin
               if (rx_d && !rx_s2) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (at_dec && maj) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (at_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (at_dec)
                  shreg <= {maj, shreg[DATA_BITS-1:1]};
               if (at_end) begin
                  if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= PAR_ACT ? PAR : STOP;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PAR: begin
               if (at_dec)
                  par_bad <= maj ^ par_exp;
               if (at_end)
                  state <= STOP;
            end
`endif
            STOP: begin
               // leave mid stop bit so a back-to-back start edge is seen
               if (at_dec) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  par_bad      <= 1'b0;
                  m.po_data    <= shreg;
                  m.frame_err  <= !maj;
                  m.parity_err <= par_bad && PAR_ACT;
                  m.po_valid   <= 1'b1;
                  m.overrun    <= m.po_valid && !m.po_ready;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule
